// File: rtl/win33_atma.sv
// Winograd F(2x2,3x3) back end: M = U .* V, Y = At*M*A, optional psum add.
// One tile every 5 cycles: y_out is valid 3 cycles after the capture edge.
module win33_atma #(
  parameter int DW = 16,
  parameter int AW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [4*DW-1:0]   v_row1,
  input  logic [4*DW-1:0]   v_row2,
  input  logic [4*DW-1:0]   v_row3,
  input  logic [4*DW-1:0]   v_row4,
  input  logic [4*DW-1:0]   u_row1,
  input  logic [4*DW-1:0]   u_row2,
  input  logic [4*DW-1:0]   u_row3,
  input  logic [4*DW-1:0]   u_row4,
  input  logic              acc_en,
  input  logic [4*AW-1:0]   psum_in,
  output logic [4*AW-1:0]   y_out,
  output logic              end_signal,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, MUL, ROW, COL, DONE} state_t;

  state_t state, state_nx;

  logic [4*DW-1:0]        v_q [4];
  logic [4*DW-1:0]        u_q [4];
  logic                   acc_q;
  logic [4*AW-1:0]        psum_q;
  logic signed [AW-1:0]   m_q [4][4];
  logic signed [AW-1:0]   t0_q [4];
  logic signed [AW-1:0]   t1_q [4];
  logic signed [AW-1:0]   y_nx [4];

  // Element c (0-based) of a packed row; c=0 sits in the MSBs.
  function automatic logic signed [DW-1:0] elem(input logic [4*DW-1:0] row, input int c);
    return row[4*DW-1-DW*c -: DW];
  endfunction

  // Operands are sign-extended first so the truncated product is the exact signed result.
  function automatic logic signed [AW-1:0] mul(input logic signed [DW-1:0] a,
                                               input logic signed [DW-1:0] b);
    logic signed [AW-1:0] ax, bx;
    ax = AW'(a);
    bx = AW'(b);
    return ax * bx;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable) state_nx = MUL;
      MUL:     state_nx = ROW;
      ROW:     state_nx = COL;
      COL:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    y_nx[0] = t0_q[0] + t0_q[1] + t0_q[2];
    y_nx[1] = t0_q[1] - t0_q[2] - t0_q[3];
    y_nx[2] = t1_q[0] + t1_q[1] + t1_q[2];
    y_nx[3] = t1_q[1] - t1_q[2] - t1_q[3];
    if (acc_q) begin
      for (int i = 0; i < 4; i++) y_nx[i] = y_nx[i] + psum_q[4*AW-1-AW*i -: AW];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 4; r++) begin
        v_q[r]  <= '0;
        u_q[r]  <= '0;
        t0_q[r] <= '0;
        t1_q[r] <= '0;
        for (int c = 0; c < 4; c++) m_q[r][c] <= '0;
      end
      acc_q      <= 1'b0;
      psum_q     <= '0;
      y_out      <= '0;
      end_signal <= 1'b0;
    end else begin
      end_signal <= (state == COL);
      case (state)
        IDLE: begin
          if (enable) begin
            v_q[0] <= v_row1;
            v_q[1] <= v_row2;
            v_q[2] <= v_row3;
            v_q[3] <= v_row4;
            u_q[0] <= u_row1;
            u_q[1] <= u_row2;
            u_q[2] <= u_row3;
            u_q[3] <= u_row4;
            acc_q  <= acc_en;
            psum_q <= psum_in;
          end
        end
        MUL: begin
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
              m_q[r][c] <= mul(elem(v_q[r], c), elem(u_q[r], c));
        end
        ROW: begin
          for (int c = 0; c < 4; c++) begin
            t0_q[c] <= m_q[0][c] + m_q[1][c] + m_q[2][c];
            t1_q[c] <= m_q[1][c] - m_q[2][c] - m_q[3][c];
          end
        end
        COL: y_out <= {y_nx[0], y_nx[1], y_nx[2], y_nx[3]};
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_win33_atma.sv
// Scoreboarded bench for win33_atma: directed tiles, streaming enable, mid-tile reset.
`timescale 1ns/1ps
module tb_win33_atma;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [63:0]   v [4];
  logic [63:0]   u [4];
  logic          acc_en;
  logic [127:0]  psum_in;
  logic [127:0]  y_out;
  logic          end_signal;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulses = 0;
  logic prev_end = 1'b0;
  logic [127:0] exp_q [$];
  int           exp_cyc_q [$];

  win33_atma #(.DW(16), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .v_row1(v[0]), .v_row2(v[1]), .v_row3(v[2]), .v_row4(v[3]),
    .u_row1(u[0]), .u_row2(u[1]), .u_row3(u[2]), .u_row4(u[3]),
    .acc_en(acc_en), .psum_in(psum_in),
    .y_out(y_out), .end_signal(end_signal), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference Y(i,j) = sum_r sum_c At[i][r] * M[r][c] * At[j][c].
  function automatic logic [127:0] golden(input logic [63:0] vv [4], input logic [63:0] uu [4],
                                          input logic acc, input logic [127:0] p);
    int at [2][4];
    logic signed [31:0] mm [4][4];
    logic signed [31:0] y [2][2];
    logic signed [15:0] a, b;
    at[0] = '{1, 1, 1, 0};
    at[1] = '{0, 1, -1, -1};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        a = vv[r][63-16*c -: 16];
        b = uu[r][63-16*c -: 16];
        mm[r][c] = 32'(a) * 32'(b);
      end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        y[i][j] = 0;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            y[i][j] = y[i][j] + 32'(at[i][r] * at[j][c]) * mm[r][c];
        if (acc) y[i][j] = y[i][j] + p[127-32*(2*i+j) -: 32];
      end
    return {y[0][0], y[0][1], y[1][0], y[1][1]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every end_signal pulse.
  always @(negedge clk) begin
    if (end_signal) begin
      pulses++;
      check("end_not_back_to_back", {127'b0, prev_end}, 128'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_end_pulse", 128'd1, 128'd0);
      end else begin
        check("y_out", y_out, exp_q.pop_front());
        check("latency_cycle", 128'(cyc), 128'(exp_cyc_q.pop_front()));
      end
    end
    prev_end = end_signal;
  end

  task automatic fill(input logic [15:0] vv, input logic [15:0] uu);
    for (int r = 0; r < 4; r++) begin
      v[r] = {4{vv}};
      u[r] = {4{uu}};
    end
  endtask

  // One-cycle enable pulse; capture happens on the next posedge, result 3 edges later.
  task automatic run_tile(input logic [127:0] exp);
    @(negedge clk);
    enable = 1'b1;
    exp_q.push_back(exp);
    exp_cyc_q.push_back(cyc + 4);
    @(negedge clk);
    enable = 1'b0;
    fill($urandom, $urandom);
    acc_en = $urandom;
    psum_in = {$urandom, $urandom, $urandom, $urandom};
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int start;
    rst_n = 1'b0; enable = 1'b0; acc_en = 1'b0; psum_in = '0;
    fill(16'h0, 16'h0);
    repeat (3) @(negedge clk);
    check("reset_y_out", y_out, 128'd0);
    check("reset_busy", {127'b0, busy}, 128'd0);
    check("reset_end", {127'b0, end_signal}, 128'd0);
    rst_n = 1'b1;

    fill(16'h0001, 16'h0001); acc_en = 1'b0;
    run_tile({32'd9, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'd1});

    fill(16'h0, 16'h0);
    v[0][63:48] = 16'h8000; u[0][63:48] = 16'h8000; acc_en = 1'b0;
    run_tile({32'h40000000, 32'h0, 32'h0, 32'h0});

    fill(16'h0001, 16'h0001); acc_en = 1'b1; psum_in = {4{32'd100}};
    run_tile({32'd109, 32'd97, 32'd97, 32'd101});

    fill(16'h7FFF, 16'h7FFF); acc_en = 1'b0;
    run_tile({32'h3FF70009, 32'h4002FFFD, 32'h4002FFFD, 32'h3FFF0001});

    // Streaming: captures land on steps 0,5,10,15; other steps drive junk.
    pulses = 0;
    start = cyc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      enable = 1'b1;
      fill($urandom, $urandom);
      v[i % 4][31:16] = 16'(i * 37 - 300);
      acc_en = $urandom;
      psum_in = {$urandom, $urandom, $urandom, $urandom};
      if (i % 5 == 0) begin
        exp_q.push_back(golden(v, u, acc_en, psum_in));
        exp_cyc_q.push_back(cyc + 4);
      end
    end
    @(negedge clk);
    enable = 1'b0;
    repeat (6) @(negedge clk);
    check("stream_pulse_count", 128'(pulses), 128'd4);

    // Mid-tile reset while in ROW must abort silently.
    fill(16'h0003, 16'h0005); acc_en = 1'b0;
    @(negedge clk); enable = 1'b1;
    @(negedge clk); enable = 1'b0;
    @(negedge clk);
    check("pre_reset_busy", {127'b0, busy}, 128'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_y_out", y_out, 128'd0);
    check("abort_busy", {127'b0, busy}, 128'd0);
    check("abort_end", {127'b0, end_signal}, 128'd0);
    pulses = 0;
    repeat (5) @(negedge clk);
    check("abort_no_pulse", 128'(pulses), 128'd0);

    fill(16'h0002, 16'hFFFF); acc_en = 1'b1; psum_in = {32'd5, 32'd6, 32'd7, 32'd8};
    run_tile({32'hFFFFFFEE + 32'd5, 32'd6 + 32'd6, 32'd6 + 32'd7, 32'd8 - 32'd2});

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
